// File: rtl/airport_pkg.sv
// Shared types and codes for the checkpoint lane scheduler.
// Class codes double as sel values and as req/grant bit positions.
package airport_pkg;

    localparam logic [1:0] CLS_REGULAR  = 2'b00;
    localparam logic [1:0] CLS_BUSINESS = 2'b01;
    localparam logic [1:0] CLS_VIP      = 2'b10;

    localparam int REQ_REG = 0;
    localparam int REQ_BUS = 1;
    localparam int REQ_VIP = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SERVE
    } sched_state_t;

    function automatic logic [2:0] cls_onehot(input logic [1:0] cls);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (cls)
            CLS_REGULAR:  oh[REQ_REG] = 1'b1;
            CLS_BUSINESS: oh[REQ_BUS] = 1'b1;
            CLS_VIP:      oh[REQ_VIP] = 1'b1;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/lane_scheduler_starve_counter.sv
// Saturating count of decisions a waiting class was passed over.
// starved rises once the count reaches LIMIT and holds until cleared.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic starved
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign starved = (cnt_q >= CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !starved) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lane_scheduler.sv
// Strict-priority checkpoint arbiter with starvation boost for Regular/Business.
// IDLE decides, GRANT announces for one cycle, SERVE waits for done or timeout.
module lane_scheduler
    import airport_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255,
    parameter int TMR_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [2:0] grant,
    output logic       grant_valid,
    output logic       busy,
    output logic       timeout_flag
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    sched_state_t     state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       grant_q, grant_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             to_q, to_d;

    logic       decide;
    logic [1:0] win;
    logic       starved_reg, starved_bus;
    logic       clr_reg, inc_reg, clr_bus, inc_bus;

    assign decide = (state_q == IDLE) && (req != 3'b000);

    // Boosted classes beat VIP; Regular's boost is checked first.
    always_comb begin
        win = CLS_REGULAR;
        if (req[REQ_REG] && starved_reg) begin
            win = CLS_REGULAR;
        end else if (req[REQ_BUS] && starved_bus) begin
            win = CLS_BUSINESS;
        end else if (req[REQ_VIP]) begin
            win = CLS_VIP;
        end else if (req[REQ_BUS]) begin
            win = CLS_BUSINESS;
        end else begin
            win = CLS_REGULAR;
        end
    end

    assign clr_reg = decide && (!req[REQ_REG] || win == CLS_REGULAR);
    assign inc_reg = decide && req[REQ_REG] && (win != CLS_REGULAR);
    assign clr_bus = decide && (!req[REQ_BUS] || win == CLS_BUSINESS);
    assign inc_bus = decide && req[REQ_BUS] && (win != CLS_BUSINESS);

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_wait_reg (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_reg),
        .inc     (inc_reg),
        .starved (starved_reg)
    );

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_wait_bus (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_bus),
        .inc     (inc_bus),
        .starved (starved_bus)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        timer_d = timer_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (decide) begin
                    state_d = GRANT;
                    sel_d   = win;
                    grant_d = cls_onehot(win);
                end
            end
            GRANT: begin
                state_d = SERVE;
                timer_d = '0;
            end
            SERVE: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                    to_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= CLS_REGULAR;
            grant_q <= 3'b000;
            timer_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            timer_q <= timer_d;
            to_q    <= to_d;
        end
    end

    assign sel          = sel_q;
    assign grant        = grant_q;
    assign grant_valid  = (state_q == GRANT);
    assign busy         = (state_q != IDLE);
    assign timeout_flag = to_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with a per-cycle service-age model.
// Literal expectations pin the model on the reference scenarios.
module tb_lane_scheduler;

    localparam int L = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       grant_valid;
    logic       busy;
    logic       timeout_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int gv_cnt  = 0;

    lane_scheduler #(
        .STARVE_LIMIT (L),
        .TIMEOUT      (T),
        .TMR_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .sel          (sel),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age<0 idle, age 0 = grant cycle, age k>=1 = k-th serve cycle.
    int         age = -1;
    int         wt[2];
    int         m_sel = 0;
    int         m_grant = 0;
    int         m_to = 0;

    function automatic int pick(input logic [2:0] r, input int w0, input int w1);
        if (r[0] && w0 >= L) return 0;
        if (r[1] && w1 >= L) return 1;
        if (r[2]) return 2;
        if (r[1]) return 1;
        return 0;
    endfunction

    always begin
        @(posedge clk);
        if (rst) begin
            age = -1;
            wt[0] = 0;
            wt[1] = 0;
            m_sel = 0;
            m_grant = 0;
            m_to = 0;
        end else begin
            m_to = 0;
            if (age < 0) begin
                if (req != 3'b000) begin
                    int w;
                    w = pick(req, wt[0], wt[1]);
                    for (int c = 0; c < 2; c++) begin
                        if (c == w || !req[c]) wt[c] = 0;
                        else if (wt[c] < L) wt[c] = wt[c] + 1;
                    end
                    m_sel = w;
                    m_grant = 1 << w;
                    age = 0;
                end
            end else if (age == 0) begin
                age = 1;
            end else if (done) begin
                age = -1;
                m_grant = 0;
            end else if (age == T) begin
                age = -1;
                m_grant = 0;
                m_to = 1;
            end else begin
                age = age + 1;
            end
        end
        #1;
        check("cyc_sel", int'(sel), m_sel);
        check("cyc_grant", int'(grant), m_grant);
        check("cyc_grant_valid", int'(grant_valid), (age == 0) ? 1 : 0);
        check("cyc_busy", int'(busy), (age >= 0) ? 1 : 0);
        check("cyc_timeout_flag", int'(timeout_flag), m_to);
        if (grant_valid) gv_cnt++;
    end

    task automatic wait_gv();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gv_wait_expired", 0, 1);
    endtask

    initial begin
        int bc;
        int sc;
        int wins[6];
        int exp_w[6];
        exp_w = '{2, 2, 2, 2, 0, 2};

        rst = 1'b1;
        req = 3'b000;
        done = 1'b0;

        // Reset then idle.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gv_cnt = 0;
        repeat (10) @(negedge clk);
        check("idle_gv_count", gv_cnt, 0);
        check("idle_grant", int'(grant), 0);
        check("idle_sel", int'(sel), 0);
        check("idle_busy", int'(busy), 0);

        // All classes once: VIP wins, busy spans 4 cycles.
        req = 3'b111;
        bc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req = 3'b000;
                check("all_gv_latency", int'(grant_valid), 1);
                check("all_sel", int'(sel), 2);
                check("all_grant", int'(grant), 4);
            end
            if (busy) bc++;
            done = (i == 3);
        end
        done = 1'b0;
        check("all_busy_cycles", bc, 4);

        // Starvation boost sequence.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 3'b101;
        for (int k = 0; k < 6; k++) begin
            wait_gv();
            wins[k] = int'(sel);
            @(negedge clk);
            done = 1'b1;
            if (k == 5) req = 3'b000;
            @(negedge clk);
            done = 1'b0;
        end
        for (int k = 0; k < 6; k++) check("starve_winner", wins[k], exp_w[k]);

        // Timeout.
        @(negedge clk);
        req = 3'b010;
        wait_gv();
        req = 3'b000;
        sc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
            sc++;
        end
        check("to_serve_cycles", sc, T);
        check("to_flag_pulse", int'(timeout_flag), 1);
        check("to_grant_cleared", int'(grant), 0);
        @(negedge clk);
        check("to_flag_single", int'(timeout_flag), 0);
        req = 3'b001;
        wait_gv();
        req = 3'b000;
        check("to_next_sel", int'(sel), 0);
        check("to_next_grant", int'(grant), 1);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;

        // done on the last timer cycle wins.
        @(negedge clk);
        req = 3'b010;
        wait_gv();
        req = 3'b000;
        sc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
            sc++;
            if (sc == T) done = 1'b1;
        end
        done = 1'b0;
        check("race_serve_cycles", sc, T);
        check("race_no_timeout", int'(timeout_flag), 0);
        @(negedge clk);
        check("race_no_timeout_late", int'(timeout_flag), 0);

        // Reset during SERVE.
        req = 3'b010;
        wait_gv();
        req = 3'b000;
        check("rst_pre_grant", int'(grant), 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_grant", int'(grant), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gv", int'(grant_valid), 0);
        check("rst_to", int'(timeout_flag), 0);
        req = 3'b001;
        wait_gv();
        req = 3'b000;
        check("rst_after_sel", int'(sel), 0);
        check("rst_after_grant", int'(grant), 1);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
